// File: rtl/digit_matcher_if.sv
// Bus between the digit matcher and its host: sample buffer writes, run control,
// template-ROM lookup and the match result.
interface digit_matcher_if;
    logic        start;
    logic        sample_we;
    logic [3:0]  sample_addr;
    logic [0:15] sample_row;
    logic [3:0]  tmpl_sel;
    logic [3:0]  tmpl_addr;
    logic [0:15] tmpl_row;
    logic        busy;
    logic        done;
    logic        valid;
    logic [3:0]  digit;
    logic [8:0]  score;

    modport slave (
        input  start, sample_we, sample_addr, sample_row, tmpl_row,
        output tmpl_sel, tmpl_addr, busy, done, valid, digit, score
    );

    modport master (
        output start, sample_we, sample_addr, sample_row, tmpl_row,
        input  tmpl_sel, tmpl_addr, busy, done, valid, digit, score
    );
endinterface

// File: rtl/digit_matcher.sv
// Scores a 16x16 binarized sample against NUM_TMPL templates, one row per cycle,
// and reports the template with the most matching pixels (ties keep the lower index).
module digit_matcher #(
    parameter int NUM_TMPL = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    digit_matcher_if.slave bus
);
    localparam logic [3:0] LAST_SEL = 4'(NUM_TMPL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state;
    logic [0:15] sample [16];
    logic [3:0]  sel_q;
    logic [3:0]  addr_q;
    logic [8:0]  acc;
    logic [8:0]  best_score;
    logic [3:0]  best_digit;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic [3:0]  digit_q;
    logic [8:0]  score_q;

    logic [0:15] same_bits;
    logic [4:0]  row_match;
    logic [8:0]  total;

    always_comb begin
        same_bits = ~(sample[addr_q] ^ bus.tmpl_row);
        row_match = '0;
        for (int i = 0; i < 16; i++) begin
            row_match = row_match + 5'(same_bits[i]);
        end
        total = acc + {4'd0, row_match};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            acc        <= '0;
            best_score <= '0;
            best_digit <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            digit_q    <= '0;
            score_q    <= '0;
            for (int r = 0; r < 16; r++) begin
                sample[r] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_we) begin
                        sample[bus.sample_addr] <= bus.sample_row;
                    end
                    if (bus.start) begin
                        state      <= SCAN;
                        busy_q     <= 1'b1;
                        sel_q      <= '0;
                        addr_q     <= '0;
                        acc        <= '0;
                        best_score <= '0;
                        best_digit <= '0;
                        valid_q    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (addr_q == 4'd15) begin
                        acc    <= '0;
                        addr_q <= '0;
                        // Template 0 always seeds the best, so an all-zero score still reports digit 0
                        if (total > best_score || sel_q == 4'd0) begin
                            best_score <= total;
                            best_digit <= sel_q;
                        end
                        if (sel_q == LAST_SEL) begin
                            state <= DONE;
                            sel_q <= '0;
                        end else begin
                            sel_q <= sel_q + 4'd1;
                        end
                    end else begin
                        acc    <= total;
                        addr_q <= addr_q + 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    digit_q <= best_digit;
                    score_q <= best_score;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tmpl_sel  = sel_q;
    assign bus.tmpl_addr = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.valid     = valid_q;
    assign bus.digit     = digit_q;
    assign bus.score     = score_q;
endmodule

// File: tb/tb_digit_matcher.sv
// Self-checking bench for digit_matcher: directed template scenarios plus randomized
// runs, all compared every cycle against a run-level behavioural model.
module tb_digit_matcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_matcher_if bus ();
    digit_matcher #(.NUM_TMPL(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [0:15] rom [16][16];
    logic [0:15] smp [16];
    assign bus.tmpl_row = rom[bus.tmpl_sel][bus.tmpl_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the result of a whole run is known at the start edge;
    // the cycle position alone tells where the template scan must be.
    logic [0:15] m_sample [16];
    bit          m_active, m_done, m_valid;
    int          m_n;
    logic [3:0]  m_digit, m_res_digit;
    logic [8:0]  m_score, m_res_score;

    function automatic void best_match(output logic [3:0] d, output logic [8:0] s);
        int best = -1;
        d = '0;
        for (int t = 0; t < 10; t++) begin
            int tot = 0;
            for (int r = 0; r < 16; r++) tot += $countones(~(m_sample[r] ^ rom[t][r]));
            if (tot > best) begin
                best = tot;
                d = 4'(t);
            end
        end
        s = 9'(best);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 16; r++) m_sample[r] = '0;
            m_active = 0; m_done = 0; m_valid = 0; m_n = 0;
            m_digit = '0; m_score = '0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (bus.sample_we) m_sample[bus.sample_addr] = bus.sample_row;
                if (bus.start) begin
                    m_active = 1;
                    m_n = 0;
                    m_valid = 0;
                    best_match(m_res_digit, m_res_score);
                end
            end else begin
                m_n++;
                if (m_n == 161) begin
                    m_active = 0;
                    m_done = 1;
                    m_valid = 1;
                    m_digit = m_res_digit;
                    m_score = m_res_score;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit scanning;
        scanning = m_active && m_n < 160;
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("valid", 32'(bus.valid), 32'(m_valid));
        chk("tmpl_sel", 32'(bus.tmpl_sel), scanning ? 32'(m_n / 16) : 32'd0);
        chk("tmpl_addr", 32'(bus.tmpl_addr), scanning ? 32'(m_n % 16) : 32'd0);
        if (m_valid) begin
            chk("digit", 32'(bus.digit), 32'(m_digit));
            chk("score", 32'(bus.score), 32'(m_score));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rows(input int count);
        for (int r = 0; r < count; r++) begin
            bus.sample_we = 1'b1;
            bus.sample_addr = 4'(r);
            bus.sample_row = smp[r];
            tick();
        end
        bus.sample_we = 1'b0;
    endtask

    // Caller may pre-set sample_we/addr/row to write in the start cycle.
    task automatic run(output int lat);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.sample_we = 1'b0;
        lat = 0;
        while (!bus.done && lat < 400) begin
            tick();
            lat++;
        end
        if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
        chk("latency", 32'(lat), 32'd161);
    endtask

    task automatic rand_rom();
        for (int t = 0; t < 16; t++)
            for (int r = 0; r < 16; r++) rom[t][r] = 16'($urandom);
    endtask

    initial begin
        int lat, dones, done_at;
        logic [0:15] tmp;
        bus.start = 1'b0;
        bus.sample_we = 1'b0;
        bus.sample_addr = '0;
        bus.sample_row = '0;
        rand_rom();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_digit", 32'(bus.digit), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Sample equals template 5 exactly
        for (int r = 0; r < 16; r++) smp[r] = rom[5][r];
        load_rows(16);
        run(lat);
        chk("t5_digit", 32'(bus.digit), 32'd5);
        chk("t5_score", 32'(bus.score), 32'd256);
        chk("t5_valid", 32'(bus.valid), 32'd1);
        tick();

        // All-ones templates except an all-zero template 7; zero sample
        for (int t = 0; t < 16; t++)
            for (int r = 0; r < 16; r++) rom[t][r] = (t == 7) ? 16'h0000 : 16'hFFFF;
        for (int r = 0; r < 16; r++) smp[r] = '0;
        load_rows(16);
        run(lat);
        chk("t7_digit", 32'(bus.digit), 32'd7);
        chk("t7_score", 32'(bus.score), 32'd256);
        tick();

        // Every template identical to the sample: tie keeps digit 0
        for (int r = 0; r < 16; r++) smp[r] = 16'($urandom);
        for (int t = 0; t < 16; t++)
            for (int r = 0; r < 16; r++) rom[t][r] = smp[r];
        load_rows(16);
        run(lat);
        chk("tie_digit", 32'(bus.digit), 32'd0);
        chk("tie_score", 32'(bus.score), 32'd256);
        tick();

        // Sample is the inverse of every template
        for (int r = 0; r < 16; r++) smp[r] = ~rom[0][r];
        load_rows(16);
        run(lat);
        chk("inv_digit", 32'(bus.digit), 32'd0);
        chk("inv_score", 32'(bus.score), 32'd0);
        chk("inv_valid", 32'(bus.valid), 32'd1);
        tick();

        // Re-start and sample write in the middle of a scan are ignored
        rand_rom();
        for (int r = 0; r < 16; r++) smp[r] = rom[3][r];
        load_rows(16);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dones = 0;
        done_at = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == 40) begin
                bus.start = 1'b1;
                bus.sample_we = 1'b1;
                bus.sample_addr = 4'd3;
                tmp = ~rom[3][3];
                bus.sample_row = tmp;
            end
            tick();
            bus.start = 1'b0;
            bus.sample_we = 1'b0;
            if (bus.done) begin
                dones++;
                done_at = n;
            end
        end
        chk("busy_start_dones", 32'(dones), 32'd1);
        chk("busy_start_edge", 32'(done_at), 32'd161);
        chk("busy_start_digit", 32'(bus.digit), 32'd3);
        chk("busy_start_score", 32'(bus.score), 32'd256);
        run(lat);
        chk("buf_kept_score", 32'(bus.score), 32'd256);
        tick();

        // Reset in the middle of a scan
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_valid", 32'(bus.valid), 32'd0);
        chk("abort_sel", 32'(bus.tmpl_sel), 32'd0);
        chk("abort_addr", 32'(bus.tmpl_addr), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        run(lat);
        tick();

        // Randomized runs; last row written in the start cycle
        for (int k = 0; k < 6; k++) begin
            int src;
            rand_rom();
            src = $urandom_range(0, 9);
            for (int r = 0; r < 16; r++)
                smp[r] = rom[src][r] ^ 16'($urandom & $urandom & $urandom);
            load_rows(15);
            bus.sample_we = 1'b1;
            bus.sample_addr = 4'd15;
            bus.sample_row = smp[15];
            run(lat);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/digit_matcher.md
DIGIT_MATCHER -- requirements
Module: digit_matcher

Interface
REQ-001 The block SHALL take parameter NUM_TMPL, default 10, giving the number of digit templates scored, legal range 1..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a scoring run.
REQ-005 The block SHALL have port sample_we, input, 1 bit, the write enable for the sample buffer.
REQ-006 The block SHALL have port sample_addr, input, 4 bits, the sample row index.
REQ-007 The block SHALL have port sample_row, input, [0:15], the captured binarized row; bit 0 is the leftmost pixel.
REQ-008 The block SHALL have port tmpl_sel, output, 4 bits, the digit template select driving the template-ROM mux.
REQ-009 The block SHALL have port tmpl_addr, output, 4 bits, the row address driving the template-ROM addr port.
REQ-010 The block SHALL have port tmpl_row, input, [0:15], the combinational template row returned in the same cycle.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a scan is in progress.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-013 The block SHALL have port valid, output, 1 bit, high when digit/score hold a completed result.
REQ-014 The block SHALL have port digit, output, 4 bits, the best-matching template index.
REQ-015 The block SHALL have port score, output, 9 bits, the matching pixel count of the best template (0..256).

Function
REQ-016 The block SHALL hold an internal 16x16 sample buffer; sample_we=1 in IDLE writes sample_row to row sample_addr at the clock edge; sample_we in any other state is ignored.
REQ-017 The FSM SHALL have exactly the states IDLE, SCAN and DONE.
REQ-018 In IDLE with start=1, the FSM SHALL go to SCAN; tmpl_sel=0, tmpl_addr=0, accumulator=0, best_score=0, best_digit=0, valid=0.
REQ-019 Each SCAN cycle SHALL compute the row match as the popcount of XNOR(sample[tmpl_addr], tmpl_row), 5 bits, range 0..16, and add it to a 9-bit accumulator (no overflow possible; max 256).
REQ-020 When tmpl_addr=15, the block SHALL form the template total as accumulator+match; if the total is strictly greater than best_score, or tmpl_sel=0, it SHALL replace best_score/best_digit.
REQ-021 Ties SHALL keep the lower digit index.
REQ-022 After a tmpl_addr=15 cycle, the block SHALL clear the accumulator, wrap tmpl_addr to 0 and increment tmpl_sel; if tmpl_sel=NUM_TMPL-1, it SHALL go to DONE instead.
REQ-023 Otherwise, tmpl_addr SHALL increment by 1 per SCAN cycle.
REQ-024 SCAN SHALL last exactly 16*NUM_TMPL cycles (160 at default).
REQ-025 DONE SHALL last one cycle: done=1, valid=1, and digit/score loaded from best_digit/best_score; the FSM then returns to IDLE.
REQ-026 digit, score and valid SHALL hold their values until the next start is accepted.
REQ-027 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-028 start in SCAN or DONE SHALL be ignored; a request is not queued.
REQ-029 In IDLE, tmpl_sel and tmpl_addr SHALL be 0.
REQ-030 If start and sample_we are both 1 in IDLE in the same cycle, the write SHALL commit, and the run SHALL score the newly written row.
REQ-031 At default NUM_TMPL, done SHALL rise exactly 161 rising edges after the edge that samples start.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, valid=0, digit=0, score=0, tmpl_sel=0, tmpl_addr=0, accumulator=0, best registers=0, and all sample buffer bits=0.
REQ-033 A reset asserted mid-SCAN SHALL abort the run with no done pulse.
REQ-034 After rst_n rises, the block SHALL accept start on the first following edge.

Verification
REQ-035 Load sample with the digit-5 bitmap; feed tmpl_row from the 10 digit ROMs by tmpl_sel; pulse start -> done at edge 161, digit=5, score=256, valid=1.
REQ-036 Bench templates all-ones except template 7 all-zeros; sample all-zeros -> digit=7, score=256.
REQ-037 All 10 templates identical to the sample -> digit=0, score=256 (tie keeps lowest).
REQ-038 Sample equals the bitwise inverse of every template -> digit=0, score=0, valid=1.
REQ-039 Pulse start again at SCAN cycle 40 -> ignored; exactly one done pulse at edge 161; sample_we during the scan leaves the buffer unchanged.
REQ-040 Assert rst_n=0 at SCAN cycle 50 -> busy, valid, tmpl_sel and tmpl_addr are 0 before the next edge, with no done; a fresh start then completes after a full 160-cycle scan.
